// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
// Shared definitions for the instruction-fetch stage:
//   - FSM state encoding (FETCH / HOLD)
//   - NOP instruction constant and the IF/ID bubble field values
//   - IF/ID register record type
//   - small helpers: PC increment and saturating counter increment
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

  // FSM encoding, kept as plain constants so older tools and netlists that
  // expect a raw state vector stay compatible.
  localparam logic [0:0] ST_FETCH = 1'b0;  // request issued, waiting for data
  localparam logic [0:0] ST_HOLD  = 1'b1;  // skid buffer full, no request

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_PC4    = 32'h0000_0000;
  localparam logic        BUBBLE_VALID  = 1'b0;

  // Clears the two low address bits so the PC stays word aligned.
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  localparam logic [31:0] CNT_MAX       = 32'hFFFF_FFFF;

  // One IF/ID pipeline register entry.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR,
                                    pc4:   BUBBLE_PC4,
                                    valid: BUBBLE_VALID};

  // Sequential PC increment; wraps naturally modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 32'd1;
  endfunction

endpackage : if_fetch_stage_pkg

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// Single-entry skid buffer for the fetch stage. Catches an instruction word
// (and its PC+4) that memory returns in the same cycle the pipeline stalls,
// so the fetch does not have to be replayed.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (empties the buffer)
//   load_i    in   capture instr_i / pc4_i and mark the buffer full
//   clear_i   in   empty the buffer (wins over load_i)
//   instr_i   in   [31:0] instruction word to capture
//   pc4_i     in   [31:0] PC+4 belonging to instr_i
//   full_o    out  buffer holds a captured instruction
//   instr_o   out  [31:0] captured instruction
//   pc4_o     out  [31:0] captured PC+4
// -----------------------------------------------------------------------------
module fetch_skid_buf
  import if_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        full_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);

  logic        full_q,  full_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q,   pc4_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    full_d  = full_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d  = 1'b1;
      instr_d = instr_i;
      pc4_d   = pc4_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its _d value from before the edge.
      full_q <= full_d;
    end
  end

  // NOTE: the payload is only ever read while full_q is set, so it carries no
  // reset; only the full flag must come out of reset in a known state.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc4_q   <= pc4_d;
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule : fetch_skid_buf

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage: owns the PC, the FETCH/HOLD FSM and the IF/ID
// pipeline register. A word returned while the pipeline is stalled is parked
// in fetch_skid_buf and handed to IF/ID once the stall clears. A flush
// squashes IF/ID, drops the parked word and redirects the PC.
//
// Optional build feature (macro IF_PERF_CNT_EN): saturating counters of
// stalled cycles and flush cycles on StallCycOut / FlushCntOut.
//
// Parameters
//   RESET_PC        PC value loaded on reset
// Ports
//   Clk             in   rising-edge clock
//   Reset           in   asynchronous active-high reset
//   Stall           in   hold PC and IF/ID (load-use hazard)
//   Flush           in   squash IF/ID and redirect PC to BranchTarget
//   BranchTarget    in   [31:0] redirect address (low two bits ignored)
//   InstrReq        out  fetch request (high in FETCH, low in HOLD/reset)
//   InstrAddr       out  [31:0] fetch address, equal to PCOut
//   InstrValid      in   memory returns data for the current InstrAddr
//   InstrData       in   [31:0] returned instruction word
//   PCOut           out  [31:0] current PC
//   InstructionOut  out  [31:0] IF/ID instruction
//   PCAddResultOut  out  [31:0] IF/ID PC+4
//   ValidOut        out  IF/ID holds a real instruction
//   StallCycOut     out  [31:0] cycles with Stall=1   (IF_PERF_CNT_EN only)
//   FlushCntOut     out  [31:0] cycles with Flush=1   (IF_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] BranchTarget,
  output logic        InstrReq,
  output logic [31:0] InstrAddr,
  input  logic        InstrValid,
  input  logic [31:0] InstrData,
  output logic [31:0] PCOut,
  output logic [31:0] InstructionOut,
  output logic [31:0] PCAddResultOut,
  output logic        ValidOut
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] StallCycOut,
  output logic [31:0] FlushCntOut
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q,    pc_d;
  ifid_t       ifid_q,  ifid_d;

  logic        skid_load;
  logic        skid_clear;
  logic        skid_full;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;

  logic [31:0] pc_next;

  // Reset value forced onto a word boundary so PC[1:0] is zero from the start.
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

  assign pc_next = pc_plus4(pc_q);

  // ---------------------------------------------------------------------------
  // Skid buffer
  // ---------------------------------------------------------------------------
  fetch_skid_buf u_skid (
    .clk     (Clk),
    .rst     (Reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .instr_i (InstrData),
    .pc4_i   (pc_next),
    .full_o  (skid_full),
    .instr_o (skid_instr),
    .pc4_o   (skid_pc4)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM, PC and IF/ID
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_d     = ifid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (Flush) begin
      // Redirect wins over everything: whatever was in flight or parked is
      // wrong-path work.
      state_d    = ST_FETCH;
      pc_d       = BranchTarget & PC_ALIGN_MASK;
      ifid_d     = IFID_BUBBLE;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (InstrValid) begin
            if (Stall) begin
              // Data arrived but IF/ID cannot take it: park it and stop
              // requesting. PC stays put so InstrAddr does not move.
              skid_load = 1'b1;
              state_d   = ST_HOLD;
            end else begin
              ifid_d = '{instr: InstrData, pc4: pc_next, valid: 1'b1};
              pc_d   = pc_next;
            end
          end else if (!Stall) begin
            // Memory still busy: feed a bubble, keep asking for the same PC.
            ifid_d = IFID_BUBBLE;
          end
        end

        ST_HOLD: begin
          if (!Stall) begin
            // The parked word goes to IF/ID; the PC steps past it and the
            // next request goes out from FETCH.
            ifid_d     = '{instr: skid_instr, pc4: skid_pc4, valid: skid_full};
            pc_d       = pc_next;
            skid_clear = 1'b1;
            state_d    = ST_FETCH;
          end
        end

        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC_ALIGNED;
      ifid_q  <= IFID_BUBBLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Request is gated by Reset directly so an in-flight fetch is abandoned the
  // moment reset asserts, not at the next clock.
  assign InstrReq       = (state_q == ST_FETCH) && !Reset;
  assign InstrAddr      = pc_q;
  assign PCOut          = pc_q;
  assign InstructionOut = ifid_q.instr;
  assign PCAddResultOut = ifid_q.pc4;
  assign ValidOut       = ifid_q.valid;

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cyc_d = Stall ? sat_inc(stall_cyc_q) : stall_cyc_q;
    flush_cnt_d = Flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cyc_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCycOut = stall_cyc_q;
  assign FlushCntOut = flush_cnt_q;
`endif

endmodule : if_fetch_stage

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have ports: Clk  in  1  rising-edge clock; Reset  in  1  reset.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports: Stall  in  1  hold PC and IF/ID (load-use hazard); Flush  in  1  squash IF/ID and redirect PC.
REQ-005 SHALL have port BranchTarget  in  32  redirect address, used when Flush=1.
REQ-006 SHALL have ports: InstrReq  out  1  fetch request; InstrAddr  out  32  fetch address (equals PCOut).
REQ-007 SHALL have ports: InstrValid  in  1  memory returns data for the current InstrAddr; InstrData  in  32  instruction word.
REQ-008 SHALL have ports: PCOut  out  32  current PC; InstructionOut  out  32  IF/ID instruction; PCAddResultOut  out  32  IF/ID PC+4; ValidOut  out  1  IF/ID holds a real instruction.

Function
REQ-009 SHALL implement a 2-state FSM: FETCH (InstrReq=1) and HOLD (InstrReq=0, skid buffer full).
REQ-010 In FETCH, with InstrValid=1, Stall=0 and Flush=0: load IF/ID with {InstrData, PC+4, Valid=1} and set PC<=PC+4; stay in FETCH.
REQ-011 In FETCH, with InstrValid=1, Stall=1 and Flush=0: capture InstrData and PC+4 in the skid buffer; IF/ID holds; PC holds; go to HOLD.
REQ-012 In FETCH, with InstrValid=0, Stall=0 and Flush=0: load IF/ID with the bubble {32'h0, 32'h0, Valid=0}; PC holds.
REQ-013 Whenever Stall=1 and Flush=0, IF/ID SHALL hold its contents.
REQ-014 In HOLD, with Stall=0 and Flush=0: load IF/ID from the skid buffer with Valid=1, set PC<=PC+4, and go to FETCH one cycle later.
REQ-015 On Flush=1 in any state: IF/ID<=bubble, PC<={BranchTarget[31:2],2'b00}, discard the skid buffer, go to FETCH; Flush takes priority over Stall and InstrValid.
REQ-016 InstrAddr SHALL change only on an accepted fetch (REQ-010/REQ-014) or on Flush; memory aborts an in-flight access on an address change.
REQ-017 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000); PC[1:0] SHALL always be 2'b00.
REQ-018 Latency: an instruction accepted at edge N SHALL be visible on InstructionOut after edge N when not stalled.

Reset
REQ-019 While Reset=1: PC=RESET_PC, InstructionOut=0, PCAddResultOut=0, ValidOut=0, skid buffer empty, FSM=FETCH, InstrReq=0.
REQ-020 Reset asserted mid-operation SHALL abandon the outstanding fetch; the first request after release SHALL target RESET_PC.

Configuration
REQ-021 With IF_PERF_CNT_EN defined: add outputs StallCycOut[31:0] and FlushCntOut[31:0], counting cycles with Stall=1 and cycles with Flush=1, saturating at 32'hFFFFFFFF and cleared by Reset.
REQ-022 Without IF_PERF_CNT_EN: these ports and counters SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-023 A shared package SHALL hold the FSM state encoding, the NOP constant (32'h0), and the bubble field values.
REQ-024 The skid buffer (instruction plus PC+4, full flag) SHALL be a sub-module named fetch_skid_buf; PC, FSM and IF/ID SHALL stay in the top module.

Verification
REQ-025 Reset release with InstrValid tied to 1 -> InstrAddr sequence 0,4,8; InstructionOut follows one cycle later; ValidOut=1.
REQ-026 InstrValid low for 3 cycles at PC=0x10 -> ValidOut=0 for those cycles; InstrAddr held at 0x10; no PC advance.
REQ-027 Stall=1 for 2 cycles while data for 0x20 returns -> state goes to HOLD, InstrReq=0, IF/ID unchanged; after release, IF/ID=instr@0x20 with PCAddResultOut=0x24, then fetch 0x24.
REQ-028 Flush=1 with Stall=1 in HOLD, BranchTarget=0x103 -> IF/ID bubble, PC=0x100, skid buffer discarded, next fetch 0x100.
REQ-029 PC=0xFFFFFFFC fetch accepted -> PCAddResultOut=0x0 and next InstrAddr=0x0.
REQ-030 With IF_PERF_CNT_EN defined: 5 stall cycles and 2 flushes -> StallCycOut=5, FlushCntOut=2; Reset clears both to 0.
